// File: rtl/ov7670_pkg.sv
// Shared RGB565 field layout, luma weights and byte-pairing state for the pixel packer.
package ov7670_pkg;

  localparam int unsigned RGB_R_MSB = 15;
  localparam int unsigned RGB_R_LSB = 11;
  localparam int unsigned RGB_G_MSB = 10;
  localparam int unsigned RGB_G_LSB = 5;
  localparam int unsigned RGB_B_MSB = 4;
  localparam int unsigned RGB_B_LSB = 0;

  localparam logic [7:0] LUMA_W_R = 8'd77;
  localparam logic [7:0] LUMA_W_G = 8'd150;
  localparam logic [7:0] LUMA_W_B = 8'd29;

  typedef enum logic {
    IDLE    = 1'b0,
    HAVE_HI = 1'b1
  } pair_state_t;

  // Expand each field to 8 bits by replicating its MSBs, then weight-sum; weights total 256.
  function automatic logic [7:0] rgb565_luma(input logic [15:0] rgb);
    logic [4:0]  r5;
    logic [5:0]  g6;
    logic [4:0]  b5;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] acc;
    r5  = rgb[RGB_R_MSB:RGB_R_LSB];
    g6  = rgb[RGB_G_MSB:RGB_G_LSB];
    b5  = rgb[RGB_B_MSB:RGB_B_LSB];
    r8  = {r5, r5[4:2]};
    g8  = {g6, g6[5:4]};
    b8  = {b5, b5[4:2]};
    acc = 16'(r8) * 16'(LUMA_W_R) + 16'(g8) * 16'(LUMA_W_G) + 16'(b8) * 16'(LUMA_W_B);
    return acc[15:8];
  endfunction

endpackage

// File: rtl/ov7670_pix_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted only alongside a pop.
module ov7670_pix_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_data_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              wr_en;
  logic              rd_en;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign rd_en      = pop_i && !empty_o;
  assign wr_en      = push_i && (!full_o || rd_en);
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until counted in.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ov7670_pixel_packer.sv
// Pairs capture-stage bytes into RGB565 pixels, adds luma and frame tags, and buffers them
// on a valid/ready stream with sticky pairing and overflow flags.
module ov7670_pixel_packer
  import ov7670_pkg::*;
#(
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 120,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              pclk_24,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [7:0]        in_data,
  input  logic              clr_flags,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [15:0]       pix_rgb,
  output logic [7:0]        pix_gray,
  output logic [ADDR_W-2:0] pix_index,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              sync_err,
  output logic              overflow
);

  localparam int unsigned IDX_W   = ADDR_W - 1;
  localparam int unsigned ENTRY_W = 16 + 8 + IDX_W + 2;

  pair_state_t       state_q;
  logic [7:0]        hi_data_q;
  logic [ADDR_W-1:0] hi_addr_q;
  logic              s1_valid_q;
  logic [15:0]       s1_rgb_q;
  logic [IDX_W-1:0]  s1_index_q;
  logic              sync_err_q;
  logic              sync_err_d;
  logic              overflow_q;
  logic              overflow_d;

  logic              lo_matches;
  logic              pair_err;
  logic              drop;
  logic [31:0]       s1_col;
  logic              s1_sof;
  logic              s1_eol;
  logic [7:0]        s1_gray;
  logic [ENTRY_W-1:0] fifo_wr_data;
  logic [ENTRY_W-1:0] fifo_rd_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic              fifo_pop;
  logic              unused_height;

  assign unused_height = (HEIGHT != 0);

  assign lo_matches = (in_addr == (hi_addr_q + ADDR_W'(1)));
  assign pair_err   = in_valid && ((state_q == IDLE) ? in_addr[0]
                                                     : (!in_addr[0] || !lo_matches));

  // Pairing FSM; a matched low byte loads stage 1 with the assembled pixel.
  always_ff @(posedge pclk_24) begin
    if (reset) begin
      state_q    <= IDLE;
      hi_data_q  <= '0;
      hi_addr_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_rgb_q   <= '0;
      s1_index_q <= '0;
    end else begin
      s1_valid_q <= 1'b0;
      if (in_valid) begin
        unique case (state_q)
          IDLE: begin
            if (!in_addr[0]) begin
              hi_data_q <= in_data;
              hi_addr_q <= in_addr;
              state_q   <= HAVE_HI;
            end
          end
          HAVE_HI: begin
            if (in_addr[0]) begin
              if (lo_matches) begin
                s1_valid_q <= 1'b1;
                s1_rgb_q   <= {hi_data_q, in_data};
                s1_index_q <= in_addr[ADDR_W-1:1];
              end
              state_q <= IDLE;
            end else begin
              hi_data_q <= in_data;
              hi_addr_q <= in_addr;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Stage 2 is the FIFO write itself, which keeps first-pixel latency at two cycles.
  assign s1_col       = 32'(s1_index_q) % WIDTH;
  assign s1_sof       = (s1_index_q == '0);
  assign s1_eol       = (s1_col == (WIDTH - 1));
  assign s1_gray      = rgb565_luma(s1_rgb_q);
  assign fifo_wr_data = {s1_rgb_q, s1_gray, s1_index_q, s1_sof, s1_eol};
  assign fifo_pop     = pix_valid && pix_ready;
  assign drop         = s1_valid_q && fifo_full && !pix_ready;

  ov7670_pix_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (pclk_24),
    .rst_i       (reset),
    .push_i      (s1_valid_q),
    .push_data_i (fifo_wr_data),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rd_data),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  assign pix_valid = !fifo_empty;
  assign {pix_rgb, pix_gray, pix_index, pix_sof, pix_eol} = fifo_rd_data;

  // Sticky flags; a fresh error outranks a simultaneous clear.
  always_comb begin
    sync_err_d = pair_err || (sync_err_q && !clr_flags);
    overflow_d = drop || (overflow_q && !clr_flags);
  end

  // Flag registers.
  always_ff @(posedge pclk_24) begin
    if (reset) begin
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync_err_q <= sync_err_d;
      overflow_q <= overflow_d;
    end
  end

  assign sync_err = sync_err_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ov7670_pixel_packer.sv
// Bench for ov7670_pixel_packer: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_ov7670_pixel_packer;

  localparam int unsigned WIDTH  = 160;
  localparam int unsigned HEIGHT = 120;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DEPTH  = 4;

  typedef struct packed {
    logic [15:0] rgb;
    logic [7:0]  gray;
    logic [14:0] idx;
    logic        sof;
    logic        eol;
  } pix_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_addr = '0;
  logic [7:0]  in_data = '0;
  logic        clr_flags = 1'b0;
  logic        pix_ready = 1'b1;
  logic        pix_valid;
  logic [15:0] pix_rgb;
  logic [7:0]  pix_gray;
  logic [14:0] pix_index;
  logic        pix_sof;
  logic        pix_eol;
  logic        sync_err;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  pix_t mq[$];
  pix_t got[$];
  bit          pend_v = 1'b0;
  logic [15:0] pend_a = '0;
  logic [7:0]  pend_d = '0;
  bit          fly_v = 1'b0;
  pix_t        fly = '0;
  bit          m_serr = 1'b0;
  bit          m_ovf = 1'b0;

  always #5 clk = ~clk;

  ov7670_pixel_packer #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .pclk_24   (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .clr_flags (clr_flags),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_rgb   (pix_rgb),
    .pix_gray  (pix_gray),
    .pix_index (pix_index),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .sync_err  (sync_err),
    .overflow  (overflow)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic pix_t make_pix(logic [15:0] rgb, logic [14:0] idx);
    pix_t p;
    int r, g, b;
    r = int'(rgb[15:11]);
    g = int'(rgb[10:5]);
    b = int'(rgb[4:0]);
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    p.rgb  = rgb;
    p.gray = 8'((77 * r + 150 * g + 29 * b) / 256);
    p.idx  = idx;
    p.sof  = (idx == 15'd0);
    p.eol  = ((int'(idx) % WIDTH) == WIDTH - 1);
    return p;
  endfunction

  function automatic pix_t got_at(int i);
    if (i < got.size()) return got[i];
    return '0;
  endfunction

  // Reference model: pop, then land the pixel paired one cycle earlier, then pair this byte.
  always @(posedge clk) begin
    bit   err;
    bit   drop;
    bit   nv;
    pix_t np;
    err  = 1'b0;
    drop = 1'b0;
    nv   = 1'b0;
    np   = '0;
    if (reset) begin
      mq.delete();
      pend_v = 1'b0;
      fly_v  = 1'b0;
      m_serr = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      if (mq.size() > 0 && pix_ready) void'(mq.pop_front());
      if (fly_v) begin
        if (mq.size() < DEPTH) mq.push_back(fly);
        else drop = 1'b1;
      end
      if (in_valid) begin
        if (!in_addr[0]) begin
          if (pend_v) err = 1'b1;
          pend_v = 1'b1;
          pend_a = in_addr;
          pend_d = in_data;
        end else begin
          if (pend_v && in_addr == 16'(pend_a + 16'd1)) begin
            nv = 1'b1;
            np = make_pix({pend_d, in_data}, 15'(in_addr >> 1));
          end else begin
            err = 1'b1;
          end
          pend_v = 1'b0;
        end
      end
      fly_v  = nv;
      fly    = np;
      m_serr = err | (m_serr & !clr_flags);
      m_ovf  = drop | (m_ovf & !clr_flags);
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("valid", 32'(pix_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("rgb", 32'(pix_rgb), 32'(mq[0].rgb));
        check("gray", 32'(pix_gray), 32'(mq[0].gray));
        check("index", 32'(pix_index), 32'(mq[0].idx));
        check("sof", 32'(pix_sof), 32'(mq[0].sof));
        check("eol", 32'(pix_eol), 32'(mq[0].eol));
      end
      check("sync_err", 32'(sync_err), 32'(m_serr));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  // Log of every transferred entry, for directed literal checks.
  always @(negedge clk) begin
    if (!reset && pix_valid && pix_ready) begin
      got.push_back('{rgb: pix_rgb, gray: pix_gray, idx: pix_index, sof: pix_sof, eol: pix_eol});
    end
  end

  task automatic put(input logic [15:0] a, input logic [7:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_pulse();
    clr_flags = 1'b1;
    idle(1);
    clr_flags = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_rgb", 32'(pix_rgb), 32'd0);
    check("rst_gray", 32'(pix_gray), 32'd0);
    check("rst_index", 32'(pix_index), 32'd0);
    check("rst_sof", 32'(pix_sof), 32'd0);
    check("rst_eol", 32'(pix_eol), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset  = 1'b0;
    cmp_en = 1'b1;

    // 1: first pixel and its latency
    put(16'd0, 8'hF8);
    put(16'd1, 8'h00);
    check("t1_valid_n1", 32'(pix_valid), 32'd0);
    idle(1);
    check("t1_valid_n2", 32'(pix_valid), 32'd1);
    check("t1_rgb", 32'(pix_rgb), 32'hF800);
    check("t1_gray", 32'(pix_gray), 32'd76);
    check("t1_index", 32'(pix_index), 32'd0);
    check("t1_sof", 32'(pix_sof), 32'd1);
    check("t1_eol", 32'(pix_eol), 32'd0);
    idle(3);

    // 2: end of line and luma extremes
    got.delete();
    put(16'd318, 8'h12);
    put(16'd319, 8'h34);
    put(16'd4, 8'hFF);
    put(16'd5, 8'hFF);
    put(16'd6, 8'h00);
    put(16'd7, 8'h00);
    idle(4);
    check("t2_count", 32'(got.size()), 32'd3);
    check("t2_eol_rgb", 32'(got_at(0).rgb), 32'h1234);
    check("t2_eol_index", 32'(got_at(0).idx), 32'd159);
    check("t2_eol_eol", 32'(got_at(0).eol), 32'd1);
    check("t2_eol_sof", 32'(got_at(0).sof), 32'd0);
    check("t2_eol_gray", 32'(got_at(0).gray), 32'd63);
    check("t2_white_gray", 32'(got_at(1).gray), 32'd255);
    check("t2_black_gray", 32'(got_at(2).gray), 32'd0);

    // 3: pairing violations and flag clearing
    got.delete();
    put(16'd1, 8'h55);
    idle(3);
    check("t3_orphan_err", 32'(sync_err), 32'd1);
    check("t3_orphan_none", 32'(got.size()), 32'd0);
    put(16'd0, 8'h07);
    put(16'd2, 8'hE0);
    put(16'd3, 8'h1F);
    idle(3);
    check("t3_count", 32'(got.size()), 32'd1);
    check("t3_rgb", 32'(got_at(0).rgb), 32'hE01F);
    check("t3_index", 32'(got_at(0).idx), 32'd1);
    check("t3_err_held", 32'(sync_err), 32'd1);
    clr_pulse();
    check("t3_cleared", 32'(sync_err), 32'd0);
    clr_flags = 1'b1;
    put(16'd9, 8'h00);
    clr_flags = 1'b0;
    check("t3_err_beats_clr", 32'(sync_err), 32'd1);
    clr_pulse();
    check("t3_cleared2", 32'(sync_err), 32'd0);

    // 4: overflow with consumer stalled
    got.delete();
    pix_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      put(16'(2 * (20 + k)), 8'(8'h10 + k));
      put(16'(2 * (20 + k) + 1), 8'(8'h40 + k));
    end
    idle(3);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_valid", 32'(pix_valid), 32'd1);
    check("t4_head_rgb", 32'(pix_rgb), 32'h1040);
    pix_ready = 1'b1;
    idle(6);
    check("t4_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("t4_order_rgb", 32'(got_at(i).rgb), 32'({8'(8'h10 + i), 8'(8'h40 + i)}));
      check("t4_order_index", 32'(got_at(i).idx), 32'(20 + i));
    end
    clr_pulse();
    check("t4_ovf_cleared", 32'(overflow), 32'd0);

    // 5: push into a full FIFO while it pops
    got.delete();
    pix_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      put(16'(2 * (30 + k)), 8'(8'h20 + k));
      put(16'(2 * (30 + k) + 1), 8'(8'h60 + k));
    end
    idle(3);
    check("t5_full_valid", 32'(pix_valid), 32'd1);
    put(16'd68, 8'h24);
    put(16'd69, 8'h64);
    pix_ready = 1'b1;
    idle(1);
    check("t5_no_overflow", 32'(overflow), 32'd0);
    for (int k = 0; k < 3; k++) begin
      put(16'(2 * (35 + k)), 8'(8'h25 + k));
      put(16'(2 * (35 + k) + 1), 8'(8'h65 + k));
    end
    idle(8);
    check("t5_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check("t5_order_index", 32'(got_at(i).idx), 32'(30 + i));
    end
    check("t5_overflow_end", 32'(overflow), 32'd0);

    // 6: reset mid-operation
    got.delete();
    pix_ready = 1'b0;
    put(16'd80, 8'h31);
    put(16'd81, 8'h32);
    put(16'd82, 8'h33);
    put(16'd83, 8'h34);
    idle(3);
    check("t6_pre_valid", 32'(pix_valid), 32'd1);
    put(16'd84, 8'h77);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("t6_valid_after_rst", 32'(pix_valid), 32'd0);
    check("t6_rgb_after_rst", 32'(pix_rgb), 32'd0);
    check("t6_err_after_rst", 32'(sync_err), 32'd0);
    put(16'd85, 8'h88);
    idle(3);
    check("t6_orphan_err", 32'(sync_err), 32'd1);
    check("t6_no_pixel", 32'(pix_valid), 32'd0);
    pix_ready = 1'b1;
    idle(2);
    check("t6_none_out", 32'(got.size()), 32'd0);

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
